// File: rtl/fifo_push_arb.sv
// Round-robin arbiter that shares one FIFO push port among NUM_REQ producers.
// Grants bursts of up to MAX_BURST beats per owner and freezes the grant while the FIFO stalls.
module fifo_push_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 2,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_push_valid,
    output logic [DATA_WIDTH-1:0]         fifo_push_data,
    input  logic                          fifo_push_ready,
    output logic                          grant_valid,
    output logic [IDX_WIDTH-1:0]          grant_idx,
    output logic [3:0]                    burst_cnt
);

    logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_WIDTH-1:0] owner_q, owner_d;
    logic                 locked_q, locked_d;
    logic [3:0]           burst_cnt_q, burst_cnt_d;
    logic                 hold_q, hold_d;
    logic [IDX_WIDTH-1:0] hold_idx_q, hold_idx_d;

    logic                 owner_valid;
    logic                 hold_valid;
    logic                 release_lock;
    logic                 continue_burst;
    logic                 fresh_found;
    logic [IDX_WIDTH-1:0] fresh_idx;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    int                   fresh_off;
    int                   fresh_sum;
    logic                 transfer;
    logic [3:0]           cnt_next;

    always_comb begin
        owner_valid = 1'b0;
        hold_valid  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_WIDTH'(i)) owner_valid = req_valid[i];
            if (hold_idx_q == IDX_WIDTH'(i)) hold_valid = req_valid[i];
        end
    end

    // Rotate valids so bit 0 is rr_ptr, then take the lowest set bit.
    always_comb begin
        req_dbl     = {req_valid, req_valid} >> rr_ptr_q;
        req_rot     = req_dbl[NUM_REQ-1:0];
        fresh_found = 1'b0;
        fresh_off   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                fresh_found = 1'b1;
                fresh_off   = k;
            end
        end
        fresh_sum = int'(rr_ptr_q) + fresh_off;
        if (fresh_sum >= NUM_REQ) fresh_sum = fresh_sum - NUM_REQ;
        fresh_idx = IDX_WIDTH'(fresh_sum);
    end

    assign release_lock   = locked_q & ~owner_valid & ~hold_q;
    assign continue_burst = locked_q & owner_valid & (burst_cnt_q < 4'(MAX_BURST));

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (hold_q) begin
            grant_valid = hold_valid;
            grant_idx   = hold_valid ? hold_idx_q : '0;
        end else if (continue_burst) begin
            grant_valid = 1'b1;
            grant_idx   = owner_q;
        end else if (fresh_found) begin
            grant_valid = 1'b1;
            grant_idx   = fresh_idx;
        end
    end

    always_comb begin
        fifo_push_data = '0;
        req_ready      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_valid && (grant_idx == IDX_WIDTH'(i))) begin
                fifo_push_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready[i]   = fifo_push_ready;
            end
        end
    end

    assign fifo_push_valid = grant_valid;
    assign transfer        = grant_valid & fifo_push_ready;
    // A released lock means the reported burst already belongs to the new grant.
    assign burst_cnt       = release_lock ? 4'd0 : burst_cnt_q;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        locked_d    = locked_q;
        burst_cnt_d = burst_cnt_q;
        hold_d      = hold_q;
        hold_idx_d  = hold_idx_q;
        cnt_next    = 4'd0;

        if (hold_q && !hold_valid) hold_d = 1'b0;

        if (release_lock) begin
            locked_d    = 1'b0;
            burst_cnt_d = 4'd0;
        end

        if (grant_valid && !fifo_push_ready) begin
            hold_d     = 1'b1;
            hold_idx_d = grant_idx;
        end

        if (transfer) begin
            hold_d = 1'b0;
            if (locked_q && (grant_idx == owner_q)) begin
                cnt_next = burst_cnt_q + 4'd1;
            end else begin
                cnt_next = 4'd1;
                owner_d  = grant_idx;
                rr_ptr_d = (grant_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0
                                                                  : grant_idx + IDX_WIDTH'(1);
            end
            if (cnt_next == 4'(MAX_BURST)) begin
                locked_d    = 1'b0;
                burst_cnt_d = 4'd0;
            end else begin
                locked_d    = 1'b1;
                burst_cnt_d = cnt_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            locked_q    <= 1'b0;
            burst_cnt_q <= 4'd0;
            hold_q      <= 1'b0;
            hold_idx_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            locked_q    <= locked_d;
            burst_cnt_q <= burst_cnt_d;
            hold_q      <= hold_d;
            hold_idx_q  <= hold_idx_d;
        end
    end

endmodule
